// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port types: access sizes, arbiter states, bus command.
// Imported by the arbiter and its lane-alignment helper.
package common;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_D,
    ISSUE_I,
    RESP_D,
    RESP_I
  } arb_state_type;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } mem_cmd_type;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: misalign check, store enables/replication,
// and load lane extraction with sign/zero extension.
module mem_lane_align
  import common::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_wdata,
  output logic        req_misaligned,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_lane,
  input  logic        rsp_sign,
  input  logic [31:0] rsp_rdata_raw,
  output logic [31:0] rsp_rdata
);

  logic [31:0] shifted;

  assign shifted = rsp_rdata_raw >> {rsp_lane, 3'b000};

  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wdata_rep  = req_wdata;
    unique case (1'b1)
      req_size == MEM_BYTE: begin
        req_be        = 4'b0001 << req_lane;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      req_size == MEM_HALF: begin
        req_misaligned = req_lane[0];
        req_be         = 4'b0011 << req_lane;
        req_wdata_rep  = {2{req_wdata[15:0]}};
      end
      req_size == MEM_WORD: begin
        req_misaligned = |req_lane;
      end
      default: begin
        req_misaligned = 1'b1;
      end
    endcase
  end

  always_comb begin
    rsp_rdata = shifted;
    unique case (1'b1)
      rsp_size == MEM_BYTE:
        rsp_rdata = {{24{rsp_sign & shifted[7]}},
                     shifted[7:0]};
      rsp_size == MEM_HALF:
        rsp_rdata = {{16{rsp_sign & shifted[15]}},
                     shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: data beats fetch, one bus
// transaction at a time, with a watchdog on the bus ack.
module mem_port_arbiter
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_misaligned,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_type state, state_nxt;
  mem_cmd_type   cmd;
  logic [CW-1:0] wd_cnt;
  logic          wd_fire;
  logic          issue;
  logic          mis_q;
  logic          tmo_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          req_mis;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [31:0]   rsp_rdata;

  mem_lane_align u_align (
    .req_size       (d_size),
    .req_lane       (d_addr[1:0]),
    .req_wdata      (d_wdata),
    .req_misaligned (req_mis),
    .req_be         (req_be),
    .req_wdata_rep  (req_wdata),
    .rsp_size       (cmd.size),
    .rsp_lane       (cmd.addr[1:0]),
    .rsp_sign       (cmd.sign),
    .rsp_rdata_raw  (mem_rdata),
    .rsp_rdata      (rsp_rdata)
  );

  // Fires on the cycle the count would reach the limit;
  // a simultaneous ack still wins.
  assign wd_fire = (TIMEOUT_CYCLES != 0) &&
                   (32'(wd_cnt) + 32'd1 ==
                    32'(TIMEOUT_CYCLES));

  assign issue = (state == ISSUE_D) || (state == ISSUE_I);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (d_req && req_mis) state_nxt = RESP_D;
        else if (d_req)       state_nxt = ISSUE_D;
        else if (if_req)      state_nxt = ISSUE_I;
      end
      ISSUE_D: begin
        if (mem_ack || wd_fire) state_nxt = RESP_D;
      end
      ISSUE_I: begin
        if (mem_ack || wd_fire) state_nxt = RESP_I;
      end
      RESP_D:  state_nxt = IDLE;
      RESP_I:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd        <= '0;
      wd_cnt     <= '0;
      mis_q      <= 1'b0;
      tmo_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wd_cnt <= '0;
          mis_q  <= 1'b0;
          tmo_q  <= 1'b0;
          if (d_req && req_mis) begin
            mis_q     <= 1'b1;
            d_rdata_q <= '0;
          end else if (d_req) begin
            cmd <= '{addr:  d_addr,
                     we:    d_we,
                     be:    d_we ? req_be : 4'b1111,
                     wdata: req_wdata,
                     size:  d_size,
                     sign:  d_sign};
          end else if (if_req) begin
            cmd <= '{addr:  if_addr,
                     we:    1'b0,
                     be:    4'b1111,
                     wdata: 32'h0,
                     size:  MEM_WORD,
                     sign:  1'b0};
          end
        end
        ISSUE_D, ISSUE_I: begin
          if (mem_ack) begin
            if (state == ISSUE_D)
              d_rdata_q <= cmd.we ? 32'h0 : rsp_rdata;
            else
              if_rdata_q <= mem_rdata;
          end else if (wd_fire) begin
            tmo_q <= 1'b1;
            if (state == ISSUE_D) d_rdata_q  <= '0;
            else                  if_rdata_q <= '0;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = issue;
  assign mem_we    = issue & cmd.we;
  assign mem_addr  = issue ? {cmd.addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata = issue ? cmd.wdata : 32'h0;
  assign mem_be    = issue ? cmd.be : 4'b0000;

  assign if_valid     = (state == RESP_I);
  assign d_valid      = (state == RESP_D);
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign d_misaligned = d_valid & mis_q;
  assign timeout_err  = (if_valid | d_valid) & tmo_q;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule
